// File: rtl/output_buffer_pkg.sv
// output_buffer_pkg: shared FSM encoding and default parameters for the output buffer.
package output_buffer_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_FILL   = 0;
endpackage

// File: rtl/output_buffer_if.sv
// output_buffer_if: write port and dump stream of the output buffer.
interface output_buffer_if #(parameter int DATA_W = 32, parameter int ADDR_W = 3);
    logic              write_en;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] input_data;
    logic              dump_start;
    logic              dump_ready;
    logic              dump_valid;
    logic [DATA_W-1:0] dump_data;
    logic [ADDR_W-1:0] dump_addr;
    logic              dump_last;
    logic              busy;
    logic              dump_done;
    logic              write_err;
    modport master (
        output write_en, write_address, input_data, dump_start, dump_ready,
        input  dump_valid, dump_data, dump_addr, dump_last, busy, dump_done, write_err
    );
    modport slave (
        input  write_en, write_address, input_data, dump_start, dump_ready,
        output dump_valid, dump_data, dump_addr, dump_last, busy, dump_done, write_err
    );
endinterface

// File: rtl/output_buffer_mem.sv
// output_buffer_mem: single write port, registered-address read port storage.
module output_buffer_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] rd_addr_q;
    always_ff @(posedge clk) begin
        if (we) mem_q[wr_addr] <= wr_data;
        rd_addr_q <= rd_addr;
    end
    assign rd_data = mem_q[rd_addr_q];
endmodule

// File: rtl/output_buffer.sv
// output_buffer: word buffer with a written mask, streamed out in address order on request.
module output_buffer import output_buffer_pkg::*; #(
    parameter int                DATA_W = DEF_DATA_W,
    parameter int                DEPTH  = DEF_DEPTH,
    parameter int                ADDR_W = $clog2(DEPTH),
    parameter logic [DATA_W-1:0] FILL   = DATA_W'(DEF_FILL)
) (
    input  logic              clk,
    input  logic              rst_n,
    output_buffer_if.slave    bus
);
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DEPTH-1:0]  mask_q, mask_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              wr_ok;
    logic [DATA_W-1:0] rd_data;
    // Read address tracks the next pointer so the memory output matches ptr_q in LOAD.
    output_buffer_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk     (clk),
        .we      (wr_ok),
        .wr_addr (bus.write_address),
        .wr_data (bus.input_data),
        .rd_addr (ptr_d),
        .rd_data (rd_data)
    );
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mask_d  = mask_q;
        data_d  = data_q;
        wr_ok   = bus.write_en && state_q == IDLE && {1'b0, bus.write_address} < DEPTH_W;
        err_d   = bus.write_en && !wr_ok;
        if (wr_ok) mask_d[bus.write_address] = 1'b1;
        case (state_q)
            IDLE: state_d = bus.dump_start ? LOAD : IDLE;
            LOAD: begin
                data_d  = mask_q[ptr_q] ? rd_data : FILL;
                state_d = SEND;
            end
            SEND: if (bus.dump_ready) begin
                state_d = ptr_q == LAST_A ? DONE : LOAD;
                ptr_d   = ptr_q == LAST_A ? '0 : ptr_q + ADDR_W'(1);
                mask_d  = ptr_q == LAST_A ? '0 : mask_q;
                data_d  = ptr_q == LAST_A ? '0 : data_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end
    assign bus.dump_valid = state_q == SEND;
    assign bus.dump_last  = state_q == SEND && ptr_q == LAST_A;
    assign bus.dump_data  = (state_q == LOAD || state_q == SEND) ? data_q : '0;
    assign bus.dump_addr  = (state_q == LOAD || state_q == SEND) ? ptr_q : '0;
    assign bus.busy       = state_q != IDLE;
    assign bus.dump_done  = state_q == DONE;
    assign bus.write_err  = err_q;
endmodule

// File: doc/output_buffer.md
OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, word width; DEPTH, default 8, number of words (≥2); ADDR_W, default $clog2(DEPTH), address width; FILL, default 0, value emitted for unwritten words.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 write_en  input  1  write strobe.
REQ-005 write_address  input  ADDR_W  write location.
REQ-006 input_data  input  DATA_W  write data.
REQ-007 dump_start  input  1  request to stream all DEPTH words out.
REQ-008 dump_ready  input  1  consumer accepts current word.
REQ-009 dump_valid  output  1  dump_data/dump_addr/dump_last are valid.
REQ-010 dump_data  output  DATA_W  streamed word.
REQ-011 dump_addr  output  ADDR_W  address of streamed word.
REQ-012 dump_last  output  1  current word is address DEPTH-1.
REQ-013 busy  output  1  dump in progress (state ≠ IDLE).
REQ-014 dump_done  output  1  one-cycle pulse after final handshake.
REQ-015 write_err  output  1  one-cycle pulse: write rejected.

Function
REQ-016 Storage SHALL be DEPTH×DATA_W plus a DEPTH-bit written mask.
REQ-017 In IDLE, write_en SHALL store input_data at write_address on the clock edge and set its mask bit.
REQ-018 write_address ≥ DEPTH (non-power-of-two DEPTH) SHALL be ignored and pulse write_err next cycle.
REQ-019 write_en while busy=1 SHALL be ignored and pulse write_err the next cycle; memory and mask unchanged.
REQ-020 FSM states SHALL be IDLE, LOAD, SEND, DONE.
REQ-021 IDLE→LOAD on dump_start=1; dump_start in any other state ignored.
REQ-022 A write and dump_start in the same IDLE cycle: write SHALL commit and be visible in the dump.
REQ-023 LOAD SHALL register word at read pointer (FILL if mask bit clear) into dump_data, then go to SEND; first dump_valid is 2 cycles after dump_start sampled.
REQ-024 In SEND, dump_valid=1; dump_data/addr/last SHALL hold stable while dump_ready=0.
REQ-025 Handshake (valid&ready) on non-last word SHALL advance pointer and return to LOAD; each word costs ≥2 cycles.
REQ-026 Handshake on last word (addr DEPTH-1) SHALL go to DONE, clear the entire mask, reset pointer to 0.
REQ-027 DONE SHALL assert dump_done for exactly one cycle, then IDLE; busy=0 in IDLE only.
REQ-028 Words SHALL stream in ascending address 0..DEPTH-1, exactly once each.
REQ-029 dump_valid, dump_last SHALL be 0 outside SEND; dump_data, dump_addr 0 outside LOAD/SEND.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, pointer 0, mask cleared, all outputs 0, including mid-dump.
REQ-031 Memory array contents SHALL NOT be reset; mask governs visibility.
REQ-032 First dump_start is accepted on the first rising edge with rst_n=1.

Structure
REQ-033 FSM state encoding and default parameters SHALL live in shared package output_buffer_pkg.
REQ-034 Storage SHALL be sub-module output_buffer_mem (1 write port, 1 registered-address read port); FSM/mask in top.

Verification
REQ-035 Write 0xA0..0xA7 to addr 0..7, dump with ready=1 → 8 words 0xA0..0xA7, last on addr 7, done one cycle after last.
REQ-036 Write only addr 3=0xDEADBEEF, dump → addr 3 = 0xDEADBEEF, others FILL=0; second dump → all 0.
REQ-037 ready toggling 1/0 every cycle → data/addr stable while ready=0, no word lost or duplicated.
REQ-038 write_en to addr 2 during SEND → write_err pulse, dumped and later-dumped addr 2 unchanged.
REQ-039 write addr 0=0x55 in same cycle as dump_start → first streamed word 0x55.
REQ-040 rst_n=0 at addr 4 mid-dump → outputs 0 immediately; next dump streams all FILL.
